// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with a one-entry skid buffer.
// id_ready comes only from a register, and an idle EX stage sees a zeroed (NOP) payload.
module id_ex_pipe #(
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                cnt_clr,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [DATA_W-1:0]   id_reg1,
    input  logic [DATA_W-1:0]   id_reg2,
    input  logic [RADDR_W-1:0]  id_wd,
    input  logic                id_wreg,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [DATA_W-1:0]   ex_reg1,
    output logic [DATA_W-1:0]   ex_reg2,
    output logic [RADDR_W-1:0]  ex_wd,
    output logic                ex_wreg,
    output logic [CNT_W-1:0]    bubble_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Skid entry (_p0) and output entry (_p1)
    logic                vld_p0, vld_p1;
    logic [ALUOP_W-1:0]  aluop_p0, aluop_p1;
    logic [ALUSEL_W-1:0] alusel_p0, alusel_p1;
    logic [DATA_W-1:0]   reg1_p0, reg1_p1;
    logic [DATA_W-1:0]   reg2_p0, reg2_p1;
    logic [RADDR_W-1:0]  wd_p0, wd_p1;
    logic                wreg_p0, wreg_p1;

    logic accept;
    logic out_free;
    logic skid_load;

    assign id_ready  = ~vld_p0;
    assign accept    = id_valid & ~vld_p0;
    assign out_free  = ~vld_p1 | ex_ready;
    assign skid_load = ~flush & accept & (~out_free | vld_p0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (out_free) begin
            vld_p1 <= vld_p0 | accept;
            vld_p0 <= vld_p0 & accept;
        end else begin
            vld_p0 <= vld_p0 | accept;
        end
    end

    // Skid payload: meaningful only while vld_p0 is set
    always_ff @(posedge clk) begin
        if (skid_load) begin
            aluop_p0  <= id_aluop;
            alusel_p0 <= id_alusel;
            reg1_p0   <= id_reg1;
            reg2_p0   <= id_reg2;
            wd_p0     <= id_wd;
            wreg_p0   <= id_wreg;
        end
    end

    // Output payload: zero whenever the output entry is empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aluop_p1  <= '0;
            alusel_p1 <= '0;
            reg1_p1   <= '0;
            reg2_p1   <= '0;
            wd_p1     <= '0;
            wreg_p1   <= 1'b0;
        end else if (flush || (out_free && !vld_p0 && !accept)) begin
            aluop_p1  <= '0;
            alusel_p1 <= '0;
            reg1_p1   <= '0;
            reg2_p1   <= '0;
            wd_p1     <= '0;
            wreg_p1   <= 1'b0;
        end else if (out_free && vld_p0) begin
            aluop_p1  <= aluop_p0;
            alusel_p1 <= alusel_p0;
            reg1_p1   <= reg1_p0;
            reg2_p1   <= reg2_p0;
            wd_p1     <= wd_p0;
            wreg_p1   <= wreg_p0;
        end else if (out_free) begin
            aluop_p1  <= id_aluop;
            alusel_p1 <= id_alusel;
            reg1_p1   <= id_reg1;
            reg2_p1   <= id_reg2;
            wd_p1     <= id_wd;
            wreg_p1   <= id_wreg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (!vld_p1 && ex_ready && !flush) begin
            bubble_cnt <= sat_inc(bubble_cnt);
        end
    end

    assign ex_valid  = vld_p1;
    assign ex_aluop  = aluop_p1;
    assign ex_alusel = alusel_p1;
    assign ex_reg1   = reg1_p1;
    assign ex_reg2   = reg2_p1;
    assign ex_wd     = wd_p1;
    assign ex_wreg   = wreg_p1;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed and streaming checks for id_ex_pipe; a second instance with CNT_W=2
// exercises counter saturation.
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, cnt_clr, id_valid, ex_ready;
    logic        id_ready, ex_valid, id_ready2, ex_valid2;
    logic [7:0]  id_aluop, ex_aluop, ex_aluop2;
    logic [2:0]  id_alusel, ex_alusel, ex_alusel2;
    logic [31:0] id_reg1, id_reg2, ex_reg1, ex_reg2, ex_reg1_2, ex_reg2_2;
    logic [4:0]  id_wd, ex_wd, ex_wd2;
    logic        id_wreg, ex_wreg, ex_wreg2;
    logic [15:0] bubble_cnt;
    logic [1:0]  bubble_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1),
        .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_reg1(ex_reg1),
        .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr),
        .id_valid(id_valid), .id_ready(id_ready2),
        .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1),
        .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
        .ex_valid(ex_valid2), .ex_ready(ex_ready),
        .ex_aluop(ex_aluop2), .ex_alusel(ex_alusel2), .ex_reg1(ex_reg1_2),
        .ex_reg2(ex_reg2_2), .ex_wd(ex_wd2), .ex_wreg(ex_wreg2),
        .bubble_cnt(bubble_cnt2)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [80:0] pay(input logic [31:0] k);
        logic [31:0] r2;
        r2 = ~(k * 32'd3);
        return {k[7:0] ^ 8'h5A, k[2:0], 32'hA000_0000 + k, r2, k[4:0] ^ 5'h11, k[0]};
    endfunction

    function automatic logic [80:0] ex_pay();
        return {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg};
    endfunction

    task automatic drive(input logic [80:0] p);
        {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg} = p;
    endtask

    initial begin
        int          sent, rcv, cyc;
        logic        held_prev;
        logic [80:0] prev_pay;

        rst = 1'b0; flush = 0; cnt_clr = 0; id_valid = 0; ex_ready = 0;
        drive('0);
        #3;
        chk("reset_ex_valid", ex_valid, 0);
        chk("reset_payload", ex_pay(), 0);
        chk("reset_bubble", bubble_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step();
        chk("ready_after_reset", id_ready, 1);

        // single instruction, one-cycle latency
        id_valid = 1; ex_ready = 1;
        drive({8'h21, 3'd0, 32'h5, 32'h0, 5'd0, 1'b0});
        step();
        chk("lat1_valid", ex_valid, 1);
        chk("lat1_aluop", ex_aluop, 8'h21);
        chk("lat1_reg1", ex_reg1, 32'h5);
        id_valid = 0;
        step();
        chk("retire_valid", ex_valid, 0);
        chk("retire_nop", ex_pay(), 0);

        // A then B into a stalled EX
        ex_ready = 0; id_valid = 1;
        drive({8'hA1, 3'd1, 32'hAAAA, 32'h1, 5'd3, 1'b1});
        step();
        chk("A_out", ex_aluop, 8'hA1);
        chk("A_ready", id_ready, 1);
        drive({8'hB2, 3'd2, 32'hBBBB, 32'h2, 5'd4, 1'b1});
        step();
        chk("A_held", ex_aluop, 8'hA1);
        chk("skid_full_ready", id_ready, 0);
        id_valid = 0;
        step();
        chk("A_stable", ex_reg1, 32'hAAAA);
        ex_ready = 1;
        step();
        chk("B_out_valid", ex_valid, 1);
        chk("B_out", ex_aluop, 8'hB2);
        chk("B_reg1", ex_reg1, 32'hBBBB);
        chk("B_ready", id_ready, 1);
        step();
        chk("drain_valid", ex_valid, 0);

        // flush with both entries full
        ex_ready = 0; id_valid = 1;
        drive({8'hA1, 3'd1, 32'hAAAA, 32'h1, 5'd3, 1'b1});
        step();
        drive({8'hB2, 3'd2, 32'hBBBB, 32'h2, 5'd4, 1'b1});
        step();
        chk("full_ready", id_ready, 0);
        flush = 1;
        drive({8'hCC, 3'd3, 32'hCCCC, 32'h3, 5'd7, 1'b1});
        step();
        flush = 0; id_valid = 0;
        chk("flush_valid", ex_valid, 0);
        chk("flush_wreg", ex_wreg, 0);
        chk("flush_wd", ex_wd, 0);
        chk("flush_payload", ex_pay(), 0);
        chk("flush_ready", id_ready, 1);
        ex_ready = 1;
        step();
        chk("no_C_1", ex_valid, 0);
        step();
        chk("no_C_2", ex_valid, 0);
        // flush discards input offered to an empty stage
        flush = 1; id_valid = 1;
        step();
        flush = 0; id_valid = 0;
        chk("flush_drop_input", ex_valid, 0);

        // bubble counter saturation on the 2-bit instance
        cnt_clr = 1;
        step();
        chk("cnt2_clr", bubble_cnt2, 0);
        chk("cnt_clr", bubble_cnt, 0);
        cnt_clr = 0;
        step(); chk("cnt2_1", bubble_cnt2, 1);
        step(); chk("cnt2_2", bubble_cnt2, 2);
        step(); chk("cnt2_3", bubble_cnt2, 3);
        step(); chk("cnt2_sat1", bubble_cnt2, 3);
        step(); chk("cnt2_sat2", bubble_cnt2, 3);
        chk("cnt16_5", bubble_cnt, 5);
        cnt_clr = 1;
        step();
        chk("cnt2_clr_again", bubble_cnt2, 0);
        cnt_clr = 0; flush = 1;
        step();
        chk("cnt2_flush_hold", bubble_cnt2, 0);
        flush = 0; ex_ready = 0;
        step();
        chk("cnt2_stall_hold", bubble_cnt2, 0);

        // asynchronous reset while holding an instruction
        id_valid = 1;
        drive({8'h77, 3'd5, 32'h1234, 32'h5678, 5'd9, 1'b1});
        step();
        id_valid = 0;
        chk("pre_rst_valid", ex_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", ex_valid, 0);
        chk("async_rst_payload", ex_pay(), 0);
        chk("async_rst_cnt", bubble_cnt, 0);
        step();
        rst = 1'b1;
        step();
        chk("post_rst_ready", id_ready, 1);
        chk("post_rst_valid", ex_valid, 0);

        // random streaming with scoreboard
        sent = 0; rcv = 0; cyc = 0; held_prev = 0; prev_pay = '0;
        while (rcv < 1000 && cyc < 20000) begin
            id_valid = (sent < 1000) && ($urandom_range(3) != 0);
            drive(pay(sent));
            ex_ready = ($urandom_range(2) != 0);
            @(negedge clk);
            if (held_prev) chk("stream_stable", ex_pay(), prev_pay);
            if (!ex_valid) chk("stream_nop", ex_pay(), 0);
            if (ex_valid && ex_ready) begin
                chk("stream_order", ex_pay(), pay(rcv));
                rcv++;
            end
            if (id_valid && id_ready) sent++;
            held_prev = ex_valid && !ex_ready;
            prev_pay = ex_pay();
            cyc++;
            step();
        end
        chk("stream_count", rcv, 1000);
        id_valid = 0; ex_ready = 1;
        step();
        step();
        chk("stream_no_dup", ex_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter ALUOP_W, default 8: aluop field width.
REQ-002 SHALL have parameter ALUSEL_W, default 3: alusel field width.
REQ-003 SHALL have parameter DATA_W, default 32: operand width.
REQ-004 SHALL have parameter RADDR_W, default 5: destination register address width.
REQ-005 SHALL have parameter CNT_W, default 16: bubble counter width.
REQ-006 SHALL have these ports:
  clk  input  1  single clock, rising edge.
  rst  input  1  asynchronous reset, active low.
  flush  input  1  synchronous kill of all held instructions.
  cnt_clr  input  1  synchronous clear of bubble counter.
  id_valid  input  1  ID presents an instruction.
  id_ready  output  1  stage can accept this cycle.
  id_aluop  input  ALUOP_W  ALU operation.
  id_alusel  input  ALUSEL_W  result select.
  id_reg1, id_reg2  input  DATA_W  operands.
  id_wd  input  RADDR_W  destination register.
  id_wreg  input  1  write enable.
  ex_valid  output  1  EX holds a valid instruction.
  ex_ready  input  1  EX consumes this cycle.
  ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg  output  as id_*  registered payload to EX.
  bubble_cnt  output  CNT_W  count of EX-starved cycles.

Function
REQ-007 SHALL hold two payload entries: output register (OUT, drives ex_*) and skid register (SKID).
REQ-008 SHALL drive id_ready = NOT skid_valid, from a register only (no combinational path from ex_ready).
REQ-009 SHALL accept when id_valid AND id_ready; SHALL retire when ex_valid AND ex_ready.
REQ-010 SHALL, when OUT is empty or retiring: load OUT from SKID if skid_valid (clearing SKID), else from accepted input; latency input to ex_* is exactly 1 cycle when both entries empty.
REQ-011 SHALL, when OUT is held (ex_valid=1, ex_ready=0) and input accepted: load SKID; SKID full forces id_ready=0 next cycle.
REQ-012 SHALL, when OUT retires, SKID valid and input accepted same cycle: move SKID to OUT, load input to SKID.
REQ-013 SHALL preserve program order; no instruction dropped or duplicated except by flush.
REQ-014 SHALL drive ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg all zero (NOP bubble) whenever ex_valid=0.
REQ-015 SHALL on flush=1: clear ex_valid and skid_valid, force OUT payload to NOP, discard any input offered that cycle; flush overrides all other events; id_ready=1 the following cycle.
REQ-016 SHALL increment bubble_cnt each cycle ex_valid=0 AND ex_ready=1 AND flush=0; SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-017 SHALL clear bubble_cnt on cnt_clr; cnt_clr has priority over increment.
REQ-018 SHALL keep ex_* stable while ex_valid=1 and ex_ready=0.

Reset
REQ-019 SHALL on rst=0 asynchronously set ex_valid=0, skid_valid=0, all ex_* to zero, bubble_cnt=0.
REQ-020 SHALL drive id_ready=1 from the first rising edge after rst deasserts; reset mid-transfer discards both entries.

Verification
REQ-021 Empty stage, id_valid=1, id_aluop=8'h21, id_reg1=32'h5, ex_ready=1 -> next cycle ex_valid=1, ex_aluop=8'h21, ex_reg1=32'h5.
REQ-022 ex_ready=0, send A then B -> ex_* = A, id_ready=0 after B; raise ex_ready -> A, then B, each for one cycle, in order.
REQ-023 Both entries full, flush=1 with id_valid=1 (C) -> next cycle ex_valid=0, ex_wreg=0, ex_wd=0, id_ready=1; C never appears.
REQ-024 CNT_W=2, ex_ready=1, no input for 5 cycles -> bubble_cnt 1,2,3,3,3; cnt_clr=1 -> 0.
REQ-025 rst=0 asserted mid-cycle with ex_valid=1 -> immediately ex_valid=0, all ex_* zero, bubble_cnt=0, without a clock edge.
REQ-026 Random id_valid/ex_ready streaming 1000 instructions, no flush -> scoreboard sees identical payload sequence, no loss, no duplicate.
